// File: rtl/sha256_padder_if.sv
// Handshake bundle between a message word source, the padder and the SHA-256 core.
// Signal names keep the padder's point of view: *_i flows into the padder, *_o flows out of it.
interface sha256_padder_if;
    logic [31:0]  data_i;
    logic         data_vld_i;
    logic         data_last_i;
    logic [2:0]   data_bytes_i;
    logic         data_rdy_o;
    logic [511:0] blk_o;
    logic         blk_vld_o;
    logic         blk_first_o;
    logic         blk_last_o;
    logic         blk_rdy_i;

    // Padder side
    modport slave (
        input  data_i, data_vld_i, data_last_i, data_bytes_i, blk_rdy_i,
        output data_rdy_o, blk_o, blk_vld_o, blk_first_o, blk_last_o
    );

    // Source/core side
    modport master (
        output data_i, data_vld_i, data_last_i, data_bytes_i, blk_rdy_i,
        input  data_rdy_o, blk_o, blk_vld_o, blk_first_o, blk_last_o
    );
endinterface

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs a 32-bit big-endian word stream into 512-bit blocks, appends the
// 0x80 marker, zero fill and 64-bit bit length, and flags the first/last block of each message.
module sha256_padder #(
    parameter int unsigned LEN_W = 64
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    sha256_padder_if.slave  bus
);

    typedef enum logic [1:0] {StCollect, StPad, StPad2, StEmit} state_e;

    state_e             state_q, state_d;
    state_e             cont_q, cont_d;
    logic [15:0][31:0]  buf_q, buf_d;
    logic [3:0]         idx_q, idx_d;
    logic [3:0]         kidx_q, kidx_d;      // buffer index of the message's last word
    logic               full_q, full_d;      // last word carried all four bytes
    logic               pend_q, pend_d;      // 0x80 marker still owed to the next block
    logic [LEN_W-1:0]   cnt_q, cnt_d;        // message byte count
    logic               first_q, first_d;
    logic               last_q, last_d;

    logic [2:0]         nbytes;
    logic [31:0]        word_m;
    logic [LEN_W-1:0]   bit_len;
    logic [63:0]        len64;
    logic               fits;

    // Word shaping: effective byte count, byte masking and marker insertion
    always_comb begin
        nbytes = 3'd4;
        if (bus.data_last_i && bus.data_bytes_i < 3'd4) begin
            nbytes = bus.data_bytes_i;
        end
        word_m = '0;
        for (int b = 0; b < 4; b++) begin
            if (3'(b) < nbytes) begin
                word_m[31-8*b -: 8] = bus.data_i[31-8*b -: 8];
            end else if (3'(b) == nbytes) begin
                word_m[31-8*b -: 8] = 8'h80;
            end
        end
        bit_len = cnt_q << 3;
        len64 = '0;
        len64[LEN_W-1:0] = bit_len;
        fits = (!full_q && kidx_q <= 4'd13) || (full_q && kidx_q <= 4'd12);
    end

    // Next-state and buffer update
    always_comb begin
        state_d = state_q;
        cont_d  = cont_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        kidx_d  = kidx_q;
        full_d  = full_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        last_d  = last_q;
        unique case (state_q)
            StCollect: begin
                if (bus.data_vld_i) begin
                    buf_d[idx_q] = word_m;
                    idx_d = idx_q + 4'd1;
                    cnt_d = cnt_q + LEN_W'(nbytes);
                    if (bus.data_last_i) begin
                        kidx_d  = idx_q;
                        full_d  = (nbytes == 3'd4);
                        state_d = StPad;
                    end else if (idx_q == 4'd15) begin
                        last_d  = 1'b0;
                        cont_d  = StCollect;
                        state_d = StEmit;
                    end
                end
            end
            StPad: begin
                for (int i = 0; i < 16; i++) begin
                    if (4'(i) > kidx_q) begin
                        buf_d[i] = '0;
                    end
                end
                if (full_q && kidx_q != 4'd15) begin
                    buf_d[kidx_q + 4'd1] = 32'h8000_0000;
                end
                if (fits) begin
                    buf_d[14] = len64[63:32];
                    buf_d[15] = len64[31:0];
                    last_d    = 1'b1;
                end else begin
                    last_d = 1'b0;
                    cont_d = StPad2;
                    pend_d = full_q && (kidx_q == 4'd15);
                end
                state_d = StEmit;
            end
            StPad2: begin
                buf_d = '0;
                if (pend_q) begin
                    buf_d[0] = 32'h8000_0000;
                end
                buf_d[14] = len64[63:32];
                buf_d[15] = len64[31:0];
                pend_d    = 1'b0;
                last_d    = 1'b1;
                state_d   = StEmit;
            end
            StEmit: begin
                if (bus.blk_rdy_i) begin
                    buf_d = '0;
                    idx_d = '0;
                    if (last_q) begin
                        cnt_d   = '0;
                        first_d = 1'b1;
                        state_d = StCollect;
                    end else begin
                        first_d = 1'b0;
                        state_d = cont_q;
                    end
                end
            end
            default: state_d = StCollect;
        endcase
    end

    // State registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= StCollect;
            cont_q  <= StCollect;
            buf_q   <= '0;
            idx_q   <= '0;
            kidx_q  <= '0;
            full_q  <= 1'b0;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
            first_q <= 1'b1;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cont_q  <= cont_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            kidx_q  <= kidx_d;
            full_q  <= full_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    // Outputs; flags are only meaningful while a block is presented
    always_comb begin
        bus.data_rdy_o  = rstn_i && (state_q == StCollect);
        bus.blk_o       = buf_q;
        bus.blk_vld_o   = (state_q == StEmit);
        bus.blk_first_o = (state_q == StEmit) && first_q;
        bus.blk_last_o  = (state_q == StEmit) && last_q;
    end

endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench for sha256_padder: directed messages, expected blocks queued by the stimulus
// and popped by an independent monitor on each block handshake.
module tb_sha256_padder;

    logic clk_i = 1'b0;
    logic rstn_i;
    always #5 clk_i = ~clk_i;

    sha256_padder_if bus ();

    sha256_padder #(.LEN_W(64)) dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .bus    (bus)
    );

    typedef struct packed {
        logic [511:0] blk;
        logic         first;
        logic         last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(string name, logic [511:0] act, logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(int i);
        return {8'(4*i+1), 8'(4*i+2), 8'(4*i+3), 8'(4*i+4)};
    endfunction

    function automatic logic [511:0] data_blk(int n);
        logic [511:0] b = '0;
        for (int i = 0; i < n; i++) b[32*i +: 32] = word_of(i);
        return b;
    endfunction

    function automatic logic [511:0] set_w(logic [511:0] b, int i, logic [31:0] w);
        b[32*i +: 32] = w;
        return b;
    endfunction

    function automatic exp_t mk(logic [511:0] b, logic f, logic l);
        exp_t e;
        e.blk = b;
        e.first = f;
        e.last = l;
        return e;
    endfunction

    // Drive one word starting at a negedge; returns at the negedge after it is accepted
    task automatic send_word(logic [31:0] w, logic last, logic [2:0] nb);
        int guard = 0;
        bus.data_i       = w;
        bus.data_vld_i   = 1'b1;
        bus.data_last_i  = last;
        bus.data_bytes_i = nb;
        while (!bus.data_rdy_o && guard < 200) begin
            @(negedge clk_i);
            guard++;
        end
        if (guard >= 200) begin
            vectors++;
            miscompares++;
            $display("FAIL data_rdy_timeout: got data_rdy_o=0 for 200 cycles, required 1");
        end
        @(negedge clk_i);
        bus.data_vld_i  = 1'b0;
        bus.data_last_i = 1'b0;
    endtask

    task automatic send_msg(int n, logic [2:0] lb);
        for (int i = 0; i < n; i++) begin
            send_word(word_of(i), i == n - 1, (i == n - 1) ? lb : 3'd0);
        end
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 500) begin
            @(negedge clk_i);
            guard++;
        end
        if (guard >= 500) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d blocks outstanding, required 0", exp_q.size());
        end
        @(negedge clk_i);
    endtask

    // Monitor: compare every presented block against the scoreboard at handshake
    always begin
        @(negedge clk_i);
        #2;
        if (rstn_i && bus.blk_vld_o && bus.blk_rdy_i) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_blk: got block %h, required none", bus.blk_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("blk_data", bus.blk_o, mon_e.blk);
                check("blk_first_last", 512'({bus.blk_first_o, bus.blk_last_o}),
                      512'({mon_e.first, mon_e.last}));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    logic [511:0] snap;

    initial begin
        bus.data_i       = '0;
        bus.data_vld_i   = 1'b0;
        bus.data_last_i  = 1'b0;
        bus.data_bytes_i = '0;
        bus.blk_rdy_i    = 1'b1;
        rstn_i           = 1'b0;
        repeat (2) @(negedge clk_i);
        check("rst_blk", bus.blk_o, '0);
        check("rst_vld", 512'(bus.blk_vld_o), 512'(0));
        check("rst_first", 512'(bus.blk_first_o), 512'(0));
        check("rst_last", 512'(bus.blk_last_o), 512'(0));
        check("rst_data_rdy", 512'(bus.data_rdy_o), 512'(0));
        rstn_i = 1'b1;
        @(negedge clk_i);

        // "abc", preceded by a data_last_i pulse without valid that must be ignored
        bus.data_last_i  = 1'b1;
        bus.data_bytes_i = 3'd3;
        repeat (2) @(negedge clk_i);
        bus.data_last_i  = 1'b0;
        exp_q.push_back(mk(set_w(set_w('0, 0, 32'h6162_6380), 15, 32'h18), 1'b1, 1'b1));
        send_word(32'h6162_6300, 1'b1, 3'd3);
        check("lat_pad_no_vld", 512'(bus.blk_vld_o), 512'(0));
        @(negedge clk_i);
        check("lat_emit_vld", 512'(bus.blk_vld_o), 512'(1));
        wait_drain();

        // Empty message: garbage in the data word must be masked away
        exp_q.push_back(mk(set_w('0, 0, 32'h8000_0000), 1'b1, 1'b1));
        send_word(32'hDEAD_BEEF, 1'b1, 3'd0);
        wait_drain();

        // 55 bytes: marker lands in byte 3 of word 13, length fits
        exp_q.push_back(mk(set_w(set_w(data_blk(13), 13, 32'h3536_3780), 15, 32'h1B8),
                           1'b1, 1'b1));
        send_msg(14, 3'd3);
        wait_drain();

        // 56 bytes with the core stalled: marker in word 14, length spills to a second block
        bus.blk_rdy_i = 1'b0;
        exp_q.push_back(mk(set_w(data_blk(14), 14, 32'h8000_0000), 1'b1, 1'b0));
        exp_q.push_back(mk(set_w('0, 15, 32'h1C0), 1'b0, 1'b1));
        send_msg(14, 3'd4);
        begin
            int guard = 0;
            while (!bus.blk_vld_o && guard < 20) begin
                @(negedge clk_i);
                guard++;
            end
        end
        snap = bus.blk_o;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            check("stall_vld", 512'(bus.blk_vld_o), 512'(1));
            check("stall_blk", bus.blk_o, snap);
            check("stall_data_rdy", 512'(bus.data_rdy_o), 512'(0));
        end
        bus.blk_rdy_i = 1'b1;
        wait_drain();

        // 64 bytes: full data block, marker and length in a second block
        exp_q.push_back(mk(data_blk(16), 1'b1, 1'b0));
        exp_q.push_back(mk(set_w(set_w('0, 0, 32'h8000_0000), 15, 32'h200), 1'b0, 1'b1));
        send_msg(16, 3'd4);
        wait_drain();

        // data_bytes_i above 4 behaves as 4
        exp_q.push_back(mk(set_w(set_w(data_blk(1), 1, 32'h8000_0000), 15, 32'h20),
                           1'b1, 1'b1));
        send_word(word_of(0), 1'b1, 3'd7);
        wait_drain();

        // Reset while in PAD: outputs clear, the interrupted message produces nothing
        send_word(32'h6162_6300, 1'b1, 3'd3);
        rstn_i = 1'b0;
        #1;
        check("pad_rst_blk", bus.blk_o, '0);
        check("pad_rst_vld", 512'(bus.blk_vld_o), 512'(0));
        check("pad_rst_first", 512'(bus.blk_first_o), 512'(0));
        check("pad_rst_last", 512'(bus.blk_last_o), 512'(0));
        check("pad_rst_data_rdy", 512'(bus.data_rdy_o), 512'(0));
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(negedge clk_i);
        exp_q.push_back(mk(set_w(set_w('0, 0, 32'h6162_6380), 15, 32'h18), 1'b1, 1'b1));
        send_word(32'h6162_6300, 1'b1, 3'd3);
        wait_drain();
        repeat (4) @(negedge clk_i);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
